vx_tcu_csr_bank: RTL and testbench
==================================

Name: vx_tcu_csr_bank

Overview:
CSR-side responder for the tensor-core CSR interface. It holds one A tile, one B tile and one C tile of TILE_SIZE words each. The core CSR path fills A and B; the TCU streams A/B out, pushes C back in, and the CSR path reads C. It sits between the CSR unit and the TCU execute block and implements the slave end of the read_enable/read_data and write_enable/write_data handshake.

Parameters:
TILE_SIZE, 4, words per tile (power of 2, at least 2)
DATA_WIDTH, 32, word width
ADDR_W, $clog2(4*TILE_SIZE), CSR offset width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
csr_write_en  in  1  CSR write strobe
csr_read_en  in  1  CSR read strobe
csr_addr  in  ADDR_W  offset: [0,T) A; [T,2T) B; [2T,3T) C (read-only); 3T CLEAR (write-only)
csr_write_data  in  DATA_WIDTH  CSR write data
csr_read_data  out  DATA_WIDTH  CSR read data, registered
csr_read_valid  out  1  one-cycle pulse, one cycle after csr_read_en
csr_err  out  1  one-cycle pulse on rejected access
load_ready  out  1  high in ARMED (A and B complete, nothing streamed yet)
read_enable  in  1  TCU request for next A/B pair
read_data_a  out  DATA_WIDTH  A[rd_ptr], registered
read_data_b  out  DATA_WIDTH  B[rd_ptr], registered
read_valid  out  1  pulse one cycle after an accepted read_enable
load_done  out  1  pulse coincident with read_valid of the last pair
write_enable  in  1  TCU C-word push
write_data  in  DATA_WIDTH  C word
store_done  out  1  pulse the cycle after the T-th accepted C push
result_valid  out  1  high in DONE

Behaviour:
- Reset (async assert, sync deassert): state=FILL; a_vld and b_vld masks=0; rd_ptr=0, wr_ptr=0; all outputs 0. Storage is not cleared.
- FILL state:
  - CSR write to an A/B offset stores the word and sets its vld bit. Rewrites are allowed.
  - When both masks are all-ones at the clock edge, go to ARMED.
  - read_enable is ignored and pulses csr_err.
- ARMED or SERVE state:
  - Accepted read_enable: next cycle, read_data_a/b = A/B[rd_ptr] and read_valid=1; rd_ptr increments. The first accept moves ARMED to SERVE.
  - When rd_ptr==T-1 is accepted: load_done=1 with that read_valid, rd_ptr wraps to 0, go to COLLECT.
  - A/B CSR writes are rejected: csr_err pulses and storage is unchanged.
- COLLECT state:
  - write_enable stores write_data into C[wr_ptr]; wr_ptr increments.
  - The T-th push wraps wr_ptr to 0, moves to DONE and pulses store_done next cycle.
  - read_enable is ignored and pulses csr_err.
- DONE state:
  - result_valid=1.
  - CSR write to CLEAR zeroes the masks and pointers and returns to FILL. result_valid falls the next cycle.
  - A/B writes, read_enable and write_enable are ignored; a rejected A/B write pulses csr_err.
- write_enable outside COLLECT is dropped and pulses csr_err.
- CLEAR outside DONE is ignored and pulses csr_err.
- CSR reads:
  - Allowed in any state for A, B and C offsets; data is returned one cycle later.
  - A C read before DONE returns stale contents without an error.
  - A read of the CLEAR offset or any offset ≥3T+1 returns 0 and pulses csr_err.
- CSR writes to C or to offsets above 3T pulse csr_err.
- csr_write_en and csr_read_en asserted together: both are serviced. A read of the same word returns the old value (read-before-write).
- Simultaneous CSR write and TCU access are independent: separate ports, no arbitration.
- Async reset mid-SERVE or mid-COLLECT aborts immediately. Pulses drop in the same cycle, and no done pulse is issued.

Test Plan:
- Write A[i]=0x10+i and B[i]=0x20+i (i=0..3) in reverse order -> load_ready rises the cycle after the 8th write; no csr_err.
- In ARMED, assert read_enable for 4 consecutive cycles -> read_valid on cycles 1–4 with pairs (0x10,0x20)…(0x13,0x23); load_done only with the 4th pair; state COLLECT.
- In COLLECT, push 0xA0..0xA3 with one idle cycle between pushes -> store_done one cycle after the 4th push; result_valid=1; CSR reads of offsets 8..11 return 0xA0..0xA3 one cycle after each request.
- Write A[0]=0xFF during SERVE and push write_enable in FILL -> csr_err pulses each time; A[0] reads back 0x10; C is unchanged.
- In DONE, write CLEAR (offset 12) -> state FILL, result_valid=0 next cycle, load_ready=0; issuing read_enable now pulses csr_err.
- Drop reset low after 2 accepted read_enables -> all outputs 0 in the same cycle; after release, state FILL and a_vld=b_vld=0; refilling gives read_data_a starting at A[0].

Source files
------------

// File: rtl/vx_tcu_csr_bank.sv
// CSR-side A/B/C tile bank for the tensor core: CSR fills A/B, the TCU streams pairs out and pushes C back.
// Latency: CSR reads and TCU pair reads return one cycle after the strobe; all pulses are registered.
// Backpressure: none; accesses not legal in the current state are dropped and flagged on csr_err_o.
module vx_tcu_csr_bank #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = $clog2(4 * TILE_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  csr_write_en_i,
    input  logic                  csr_read_en_i,
    input  logic [ADDR_W-1:0]     csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_write_data_i,
    output logic [DATA_WIDTH-1:0] csr_read_data_o,
    output logic                  csr_read_valid_o,
    output logic                  csr_err_o,
    output logic                  load_ready_o,
    input  logic                  read_enable_i,
    output logic [DATA_WIDTH-1:0] read_data_a_o,
    output logic [DATA_WIDTH-1:0] read_data_b_o,
    output logic                  read_valid_o,
    output logic                  load_done_o,
    input  logic                  write_enable_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic                  store_done_o,
    output logic                  result_valid_o
);

    localparam int PW = $clog2(TILE_SIZE);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_ARMED   = 3'd1,
        S_SERVE   = 3'd2,
        S_COLLECT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [TILE_SIZE-1:0]  a_vld_q, a_vld_d;
    logic [TILE_SIZE-1:0]  b_vld_q, b_vld_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

    logic [DATA_WIDTH-1:0] a_mem [TILE_SIZE];
    logic [DATA_WIDTH-1:0] b_mem [TILE_SIZE];
    logic [DATA_WIDTH-1:0] c_mem [TILE_SIZE];

    logic [DATA_WIDTH-1:0] csr_read_data_q;
    logic                  csr_read_valid_q;
    logic                  csr_err_q;
    logic [DATA_WIDTH-1:0] read_data_a_q;
    logic [DATA_WIDTH-1:0] read_data_b_q;
    logic                  read_valid_q;
    logic                  load_done_q;
    logic                  store_done_q;

    // Offsets are tile-aligned because TILE_SIZE is a power of two: the top two
    // address bits select A/B/C/control and the low bits index the word.
    logic [1:0]            region;
    logic [PW-1:0]         idx;
    assign region = csr_addr_i[ADDR_W-1 -: 2];
    assign idx    = csr_addr_i[PW-1:0];

    logic                  a_we, b_we, c_we;
    logic                  pair_acc, last_pair, last_push, err;
    logic [DATA_WIDTH-1:0] csr_rd_word;

    // CSR read mux over the old storage contents (read-before-write on collisions).
    always_comb begin
        csr_rd_word = '0;
        case (region)
            2'd0:    csr_rd_word = a_mem[idx];
            2'd1:    csr_rd_word = b_mem[idx];
            2'd2:    csr_rd_word = c_mem[idx];
            default: csr_rd_word = '0;
        endcase
    end

    // Access legality, storage strobes and next-state decode.
    always_comb begin
        state_d   = state_q;
        a_vld_d   = a_vld_q;
        b_vld_d   = b_vld_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        a_we      = 1'b0;
        b_we      = 1'b0;
        c_we      = 1'b0;
        pair_acc  = 1'b0;
        last_pair = 1'b0;
        last_push = 1'b0;
        err       = 1'b0;

        // Control offset (CLEAR and everything above it) is not readable.
        if (csr_read_en_i && region == 2'd3) begin
            err = 1'b1;
        end

        if (csr_write_en_i) begin
            case (region)
                2'd0: begin
                    if (state_q == S_FILL) begin
                        a_we         = 1'b1;
                        a_vld_d[idx] = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                2'd1: begin
                    if (state_q == S_FILL) begin
                        b_we         = 1'b1;
                        b_vld_d[idx] = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                2'd2: err = 1'b1;
                default: begin
                    if (idx != '0 || state_q != S_DONE) begin
                        err = 1'b1;
                    end
                end
            endcase
        end

        if (read_enable_i) begin
            if (state_q == S_ARMED || state_q == S_SERVE) begin
                pair_acc  = 1'b1;
                last_pair = (rd_ptr_q == PW'(TILE_SIZE - 1));
            end else if (state_q == S_FILL || state_q == S_COLLECT) begin
                err = 1'b1;
            end
        end

        if (write_enable_i) begin
            if (state_q == S_COLLECT) begin
                c_we      = 1'b1;
                last_push = (wr_ptr_q == PW'(TILE_SIZE - 1));
            end else begin
                err = 1'b1;
            end
        end

        case (state_q)
            S_FILL: begin
                if (&a_vld_d && &b_vld_d) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED, S_SERVE: begin
                if (pair_acc) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = last_pair ? S_COLLECT : S_SERVE;
                end
            end
            S_COLLECT: begin
                if (c_we) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (last_push) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (csr_write_en_i && region == 2'd3 && idx == '0) begin
                    a_vld_d  = '0;
                    b_vld_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    state_d  = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control state and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_FILL;
            a_vld_q          <= '0;
            b_vld_q          <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            csr_read_data_q  <= '0;
            csr_read_valid_q <= 1'b0;
            csr_err_q        <= 1'b0;
            read_data_a_q    <= '0;
            read_data_b_q    <= '0;
            read_valid_q     <= 1'b0;
            load_done_q      <= 1'b0;
            store_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            a_vld_q          <= a_vld_d;
            b_vld_q          <= b_vld_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            csr_read_valid_q <= csr_read_en_i;
            if (csr_read_en_i) begin
                csr_read_data_q <= csr_rd_word;
            end
            csr_err_q        <= err;
            read_valid_q     <= pair_acc;
            if (pair_acc) begin
                read_data_a_q <= a_mem[rd_ptr_q];
                read_data_b_q <= b_mem[rd_ptr_q];
            end
            load_done_q      <= pair_acc && last_pair;
            store_done_q     <= last_push;
        end
    end

    // Tile storage survives reset; only the valid masks are cleared.
    always_ff @(posedge clk_i) begin
        if (a_we) a_mem[idx] <= csr_write_data_i;
        if (b_we) b_mem[idx] <= csr_write_data_i;
        if (c_we) c_mem[wr_ptr_q] <= write_data_i;
    end

    assign csr_read_data_o  = csr_read_data_q;
    assign csr_read_valid_o = csr_read_valid_q;
    assign csr_err_o        = csr_err_q;
    assign load_ready_o     = (state_q == S_ARMED);
    assign read_data_a_o    = read_data_a_q;
    assign read_data_b_o    = read_data_b_q;
    assign read_valid_o     = read_valid_q;
    assign load_done_o      = load_done_q;
    assign store_done_o     = store_done_q;
    assign result_valid_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_vx_tcu_csr_bank.sv
// Testbench for vx_tcu_csr_bank: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model predicts registered outputs for each rising edge; compared on the falling edge.
// Backpressure: not applicable; illegal accesses are expected to raise csr_err.
module tb_vx_tcu_csr_bank;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_we = 1'b0;
    logic        csr_re = 1'b0;
    logic [3:0]  csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_err;
    logic        load_ready;
    logic        rd_en = 1'b0;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        rd_valid;
    logic        load_done;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        store_done;
    logic        result_valid;

    int tests = 0;
    int fails = 0;

    vx_tcu_csr_bank #(.TILE_SIZE(T), .DATA_WIDTH(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .csr_write_en_i  (csr_we),
        .csr_read_en_i   (csr_re),
        .csr_addr_i      (csr_addr),
        .csr_write_data_i(csr_wdata),
        .csr_read_data_o (csr_rdata),
        .csr_read_valid_o(csr_rvalid),
        .csr_err_o       (csr_err),
        .load_ready_o    (load_ready),
        .read_enable_i   (rd_en),
        .read_data_a_o   (rd_a),
        .read_data_b_o   (rd_b),
        .read_valid_o    (rd_valid),
        .load_done_o     (load_done),
        .write_enable_i  (wr_en),
        .write_data_i    (wr_data),
        .store_done_o    (store_done),
        .result_valid_o  (result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_FILL, M_ARMED, M_SERVE, M_COLLECT, M_DONE} mstate_e;
    mstate_e     st = M_FILL;
    mstate_e     st0;
    logic [31:0] ma [T];
    logic [31:0] mb [T];
    logic [31:0] mc [T];
    bit          ka [T];
    bit          kb [T];
    bit          kc [T];
    bit          va [T];
    bit          vb [T];
    int          n = 0;
    int          m = 0;
    int          a;
    bit          all_loaded;
    bit          e_crv = 0, e_err = 0, e_rv = 0, e_ld = 0, e_sd = 0, e_known = 0;
    logic [31:0] e_crd = '0, e_ra = '0, e_rb = '0;

    initial begin
        for (int i = 0; i < T; i++) begin
            ka[i] = 0; kb[i] = 0; kc[i] = 0; va[i] = 0; vb[i] = 0;
            ma[i] = '0; mb[i] = '0; mc[i] = '0;
        end
    end

    // Predict what each rising edge must produce, from the tile rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st = M_FILL; n = 0; m = 0;
            for (int i = 0; i < T; i++) begin va[i] = 0; vb[i] = 0; end
            e_crv = 0; e_err = 0; e_rv = 0; e_ld = 0; e_sd = 0;
        end else begin
            st0 = st;
            e_crv = 0; e_err = 0; e_rv = 0; e_ld = 0; e_sd = 0;
            if (csr_re) begin
                e_crv = 1;
                a = int'(csr_addr);
                if (a < T)            begin e_crd = ma[a];     e_known = ka[a];     end
                else if (a < 2 * T)   begin e_crd = mb[a - T]; e_known = kb[a - T]; end
                else if (a < 3 * T)   begin e_crd = mc[a-2*T]; e_known = kc[a-2*T]; end
                else                  begin e_crd = '0; e_known = 1; e_err = 1;     end
            end
            if (csr_we) begin
                a = int'(csr_addr);
                if (a < T && st0 == M_FILL) begin
                    ma[a] = csr_wdata; ka[a] = 1; va[a] = 1;
                end else if (a < 2 * T && a >= T && st0 == M_FILL) begin
                    mb[a - T] = csr_wdata; kb[a - T] = 1; vb[a - T] = 1;
                end else if (a == 3 * T && st0 == M_DONE) begin
                    for (int i = 0; i < T; i++) begin va[i] = 0; vb[i] = 0; end
                    n = 0; m = 0; st = M_FILL;
                end else begin
                    e_err = 1;
                end
            end
            if (rd_en) begin
                if (st0 == M_ARMED || st0 == M_SERVE) begin
                    e_rv = 1; e_ra = ma[n]; e_rb = mb[n];
                    n++;
                    if (n == T) begin e_ld = 1; n = 0; st = M_COLLECT; end
                    else st = M_SERVE;
                end else if (st0 == M_FILL || st0 == M_COLLECT) begin
                    e_err = 1;
                end
            end
            if (wr_en) begin
                if (st0 == M_COLLECT) begin
                    mc[m] = wr_data; kc[m] = 1; m++;
                    if (m == T) begin m = 0; e_sd = 1; st = M_DONE; end
                end else begin
                    e_err = 1;
                end
            end
            if (st0 == M_FILL) begin
                all_loaded = 1;
                for (int i = 0; i < T; i++) if (!va[i] || !vb[i]) all_loaded = 0;
                if (all_loaded) st = M_ARMED;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("csr_read_valid", csr_rvalid, e_crv);
        chk("csr_err", csr_err, e_err);
        chk("read_valid", rd_valid, e_rv);
        chk("load_done", load_done, e_ld);
        chk("store_done", store_done, e_sd);
        chk("load_ready", load_ready, (rst_n && st == M_ARMED));
        chk("result_valid", result_valid, (rst_n && st == M_DONE));
        if (e_crv && e_known) chk("csr_read_data", csr_rdata, e_crd);
        if (e_rv) begin
            chk("read_data_a", rd_a, e_ra);
            chk("read_data_b", rd_b, e_rb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        csr_we = 0; csr_re = 0; rd_en = 0; wr_en = 0;
    endtask

    task automatic csr_wr(input int ad, input logic [31:0] d);
        csr_we = 1; csr_addr = 4'(ad); csr_wdata = d;
        step();
    endtask

    task automatic csr_rd(input int ad);
        csr_re = 1; csr_addr = 4'(ad);
        step();
    endtask

    task automatic fill(input logic [31:0] abase, input logic [31:0] bbase);
        for (int i = 0; i < T; i++) begin
            csr_wr(i, abase + 32'(i));
            csr_wr(T + i, bbase + 32'(i));
        end
    endtask

    initial begin
        repeat (3) step();
        chk("rst_load_ready", load_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        rst_n = 1;

        // Fill in reverse order; ARMED is visible right after the eighth write.
        for (int i = T - 1; i >= 0; i--) begin
            csr_wr(T + i, 32'h20 + 32'(i));
            csr_wr(i, 32'h10 + 32'(i));
        end
        chk("armed_load_ready", load_ready, 1);
        chk("armed_no_err", csr_err, 0);

        // Stream four pairs back to back.
        for (int k = 0; k < T; k++) begin
            rd_en = 1;
            step();
            chk("pair_valid", rd_valid, 1);
            chk("pair_a", rd_a, 32'h10 + 32'(k));
            chk("pair_b", rd_b, 32'h20 + 32'(k));
            chk("pair_load_done", load_done, (k == T - 1) ? 1 : 0);
        end

        // Push C with gaps.
        for (int k = 0; k < T; k++) begin
            wr_en = 1; wr_data = 32'hA0 + 32'(k);
            step();
            chk("push_store_done", store_done, (k == T - 1) ? 1 : 0);
            step();
        end
        chk("done_result_valid", result_valid, 1);
        for (int k = 0; k < T; k++) begin
            csr_rd(2 * T + k);
            chk("c_read_valid", csr_rvalid, 1);
            chk("c_read_data", csr_rdata, 32'hA0 + 32'(k));
        end

        // CLEAR, then illegal TCU accesses in FILL.
        csr_wr(3 * T, 0);
        chk("clear_result_valid", result_valid, 0);
        chk("clear_load_ready", load_ready, 0);
        rd_en = 1; step();
        chk("fill_rd_en_err", csr_err, 1);
        wr_en = 1; wr_data = 32'h55; step();
        chk("fill_wr_en_err", csr_err, 1);

        // Rewrite A[0] while serving: rejected.
        fill(32'h10, 32'h20);
        rd_en = 1; step();
        csr_wr(0, 32'hFF);
        chk("serve_write_err", csr_err, 1);
        csr_rd(0);
        chk("a0_unchanged", csr_rdata, 32'h10);
        csr_rd(2 * T);
        chk("c0_unchanged", csr_rdata, 32'hA0);
        csr_wr(3 * T, 0);
        chk("clear_outside_done_err", csr_err, 1);
        csr_rd(3 * T + 1);
        chk("bad_read_err", csr_err, 1);
        chk("bad_read_zero", csr_rdata, 0);
        for (int k = 1; k < T; k++) begin rd_en = 1; step(); end
        for (int k = 0; k < T; k++) begin wr_en = 1; wr_data = $urandom; step(); end
        csr_wr(3 * T, 0);

        // Reset after two accepted pairs.
        fill(32'h30, 32'h40);
        rd_en = 1; step();
        rd_en = 1; step();
        chk("pre_reset_valid", rd_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_read_valid", rd_valid, 0);
        chk("abort_read_a", rd_a, 0);
        chk("abort_load_ready", load_ready, 0);
        chk("abort_csr_err", csr_err, 0);
        step();
        rst_n = 1;
        chk("post_reset_load_ready", load_ready, 0);
        fill(32'h50, 32'h60);
        chk("refill_armed", load_ready, 1);
        rd_en = 1; step();
        chk("refill_first_a", rd_a, 32'h50);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
                step();
                rst_n = 1;
            end
            csr_we    = ($urandom_range(0, 3) == 0);
            csr_re    = ($urandom_range(0, 2) == 0);
            csr_addr  = 4'($urandom_range(0, 15));
            csr_wdata = $urandom;
            rd_en     = ($urandom_range(0, 1) == 0);
            wr_en     = ($urandom_range(0, 1) == 0);
            wr_data   = $urandom;
            step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
